// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
//
// Pipeline control unit for the five-stage Y86-64 core. Decides, every cycle,
// which pipeline registers hold their contents (stall) and which get a nop
// injected (bubble). It also gates condition-code writes in execute, tracks
// the run/drain/halt state of the processor, and keeps saturating performance
// counters.
//
// Ports:
//   clk         core clock, all state updates on the rising edge
//   reset       synchronous, active-high reset
//   D_icode     instruction code in the D register
//   E_icode     instruction code in the E register
//   M_icode     instruction code in the M register
//   d_srcA      source register A being decoded (0xF = none)
//   d_srcB      source register B being decoded (0xF = none)
//   E_dstM      memory destination register of the instruction in E
//   e_Cnd       branch condition evaluated in execute
//   m_stat      memory-stage status
//   W_stat      writeback status
//   F_stall     hold the fetch predicted-PC register
//   D_stall     hold the D register
//   W_stall     hold the W register
//   D_bubble    inject a nop into D
//   E_bubble    inject a nop into E
//   M_bubble    inject a nop into M
//   set_cc      allow the condition-code write in execute
//   cpu_state   00 RUN, 01 DRAIN, 10 HALTED
//   cyc_cnt     cycles spent outside HALTED
//   stall_cnt   cycles with a fetch stall outside HALTED
//   bubble_cnt  cycles with any bubble outside HALTED
// ---------------------------------------------------------------------------
module pipe_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       D_icode,
   input  logic [3:0]       E_icode,
   input  logic [3:0]       M_icode,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   input  logic [3:0]       E_dstM,
   input  logic             e_Cnd,
   input  logic [3:0]       m_stat,
   input  logic [3:0]       W_stat,
   output logic             F_stall,
   output logic             D_stall,
   output logic             W_stall,
   output logic             D_bubble,
   output logic             E_bubble,
   output logic             M_bubble,
   output logic             set_cc,
   output logic [1:0]       cpu_state,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IPOPQ   = 4'hB;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] RNONE   = 4'hF;
   localparam logic [3:0] SHLT    = 4'h2;
   localparam logic [3:0] SADR    = 4'h3;
   localparam logic [3:0] SINS    = 4'h4;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_DRAIN  = 2'b01,
      ST_HALTED = 2'b10
   } state_t;

   state_t state;
   state_t state_next;

   logic load_use;
   logic ret_busy;
   logic mispredict;
   logic m_exc;
   logic w_exc;
   logic any_bubble;

   // Hazard detection from the instructions currently occupying D/E/M.
   // A register number of 0xF means "no register", so a load into 0xF can
   // never create a load-use hazard even if the decoder also reads 0xF.
   always_comb begin
      load_use   = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) &&
                   (E_dstM != RNONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
      ret_busy   = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
      mispredict = (E_icode == IJXX) && !e_Cnd;
      m_exc      = (m_stat == SHLT) || (m_stat == SADR) || (m_stat == SINS);
      w_exc      = (W_stat == SHLT) || (W_stat == SADR) || (W_stat == SINS);
   end

   // Run-state register; reset always lands in RUN regardless of where the
   // machine was.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_RUN;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. An exception reaching W halts the machine; one still
   // in M only drains, since a mispredict or similar may yet squash it.
   always_comb begin
      state_next = state;
      case (state)
         ST_RUN: begin
            if (w_exc) begin
               state_next = ST_HALTED;
            end else if (m_exc) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_exc) begin
               state_next = ST_HALTED;
            end else if (!m_exc) begin
               state_next = ST_RUN;
            end
         end
         ST_HALTED: begin
            state_next = ST_HALTED;
         end
         default: begin
            state_next = ST_RUN;
         end
      endcase
   end

   // Stall/bubble outputs. Reset flushes the pipe with bubbles and releases
   // all stalls; HALTED freezes everything. In normal operation a load-use
   // stall takes priority over the ret bubble in D so the two never coincide.
   always_comb begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      W_stall  = 1'b0;
      D_bubble = 1'b0;
      E_bubble = 1'b0;
      M_bubble = 1'b0;
      set_cc   = 1'b0;
      if (reset) begin
         D_bubble = 1'b1;
         E_bubble = 1'b1;
         M_bubble = 1'b1;
      end else if (state == ST_HALTED) begin
         F_stall  = 1'b1;
         D_stall  = 1'b1;
         W_stall  = 1'b1;
         D_bubble = 1'b1;
         E_bubble = 1'b1;
         M_bubble = 1'b1;
      end else begin
         F_stall  = load_use || ret_busy;
         D_stall  = load_use;
         D_bubble = mispredict || (!load_use && ret_busy);
         E_bubble = mispredict || load_use;
         M_bubble = m_exc || w_exc;
         W_stall  = w_exc;
         set_cc   = (E_icode == IOPQ) && !m_exc && !w_exc;
      end
   end

   assign cpu_state  = state;
   assign any_bubble = D_bubble || E_bubble || M_bubble;

   // Saturating performance counters; nothing advances while halted.
   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_cnt    <= '0;
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else if (state != ST_HALTED) begin
         if (cyc_cnt != CNT_MAX) begin
            cyc_cnt <= cyc_cnt + CNT_ONE;
         end
         if (F_stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
         if (any_bubble && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
//
// Directed testbench for pipe_ctrl. A 32-bit counter instance carries the
// functional scenarios; a second instance with 4-bit counters shares the same
// inputs and is only examined for counter saturation.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

   logic        clk;
   logic        reset;
   logic [3:0]  D_icode, E_icode, M_icode;
   logic [3:0]  d_srcA, d_srcB, E_dstM;
   logic        e_Cnd;
   logic [3:0]  m_stat, W_stat;

   logic        F_stall, D_stall, W_stall;
   logic        D_bubble, E_bubble, M_bubble;
   logic        set_cc;
   logic [1:0]  cpu_state;
   logic [31:0] cyc_cnt, stall_cnt, bubble_cnt;

   logic        s_F_stall, s_D_stall, s_W_stall;
   logic        s_D_bubble, s_E_bubble, s_M_bubble;
   logic        s_set_cc;
   logic [1:0]  s_cpu_state;
   logic [3:0]  s_cyc_cnt, s_stall_cnt, s_bubble_cnt;

   int total;
   int bad;

   pipe_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
      .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM),
      .e_Cnd(e_Cnd), .m_stat(m_stat), .W_stat(W_stat),
      .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
      .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
      .set_cc(set_cc), .cpu_state(cpu_state),
      .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   pipe_ctrl #(.CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset),
      .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
      .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM),
      .e_Cnd(e_Cnd), .m_stat(m_stat), .W_stat(W_stat),
      .F_stall(s_F_stall), .D_stall(s_D_stall), .W_stall(s_W_stall),
      .D_bubble(s_D_bubble), .E_bubble(s_E_bubble), .M_bubble(s_M_bubble),
      .set_cc(s_set_cc), .cpu_state(s_cpu_state),
      .cyc_cnt(s_cyc_cnt), .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one full input vector, then let the combinational outputs settle.
   task automatic applyStimulus(input logic [3:0] di, input logic [3:0] ei,
                                input logic [3:0] mi, input logic [3:0] sa,
                                input logic [3:0] sb, input logic [3:0] dm,
                                input logic cnd, input logic [3:0] ms,
                                input logic [3:0] ws);
      D_icode = di; E_icode = ei; M_icode = mi;
      d_srcA  = sa; d_srcB  = sb; E_dstM  = dm;
      e_Cnd   = cnd; m_stat = ms; W_stat  = ws;
      #1;
   endtask

   // Quiet pipeline: nops everywhere, no registers, AOK status.
   task automatic idle();
      applyStimulus(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 4'h1, 4'h1);
   endtask

   // One reset cycle; on return counters are zero and reset is low.
   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      applyStimulus(4'h9, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 4'h1, 4'h1);
      total++; if (F_stall !== 1'b0) begin bad++; $display("[TB] FAIL rst_fstall: got %0b want 0", F_stall); end
      total++; if ({D_bubble, E_bubble, M_bubble} !== 3'b111) begin bad++; $display("[TB] FAIL rst_bubbles: got %03b want 111", {D_bubble, E_bubble, M_bubble}); end
      total++; if (set_cc !== 1'b0) begin bad++; $display("[TB] FAIL rst_setcc: got %0b want 0", set_cc); end
      tick();
      total++; if (cpu_state !== 2'b00) begin bad++; $display("[TB] FAIL rst_state: got %0d want 0", cpu_state); end
      total++; if ({cyc_cnt, stall_cnt, bubble_cnt} !== 96'd0) begin bad++; $display("[TB] FAIL rst_cnts: got %0d/%0d/%0d want 0/0/0", cyc_cnt, stall_cnt, bubble_cnt); end
      reset = 1'b0;
      idle();
      tick();
      total++; if (cyc_cnt !== 32'd1) begin bad++; $display("[TB] FAIL rst_first_cyc: got %0d want 1", cyc_cnt); end
   endtask

   task automatic test_load_use();
      do_reset();
      applyStimulus(4'h1, 4'h5, 4'h1, 4'h3, 4'hF, 4'h3, 1'b1, 4'h1, 4'h1);
      total++; if ({F_stall, D_stall, E_bubble, D_bubble} !== 4'b1110) begin bad++; $display("[TB] FAIL lu_ctrl: got %04b want 1110", {F_stall, D_stall, E_bubble, D_bubble}); end
      for (int i = 0; i < 3; i++) tick();
      total++; if (stall_cnt !== 32'd3) begin bad++; $display("[TB] FAIL lu_stall_cnt: got %0d want 3", stall_cnt); end
      total++; if (bubble_cnt !== 32'd3) begin bad++; $display("[TB] FAIL lu_bubble_cnt: got %0d want 3", bubble_cnt); end
      // popq matched through srcB
      applyStimulus(4'h1, 4'hB, 4'h1, 4'hF, 4'h4, 4'h4, 1'b1, 4'h1, 4'h1);
      total++; if (D_stall !== 1'b1) begin bad++; $display("[TB] FAIL lu_srcb: got %0b want 1", D_stall); end
      // dstM of 0xF never causes a hazard
      applyStimulus(4'h1, 4'h5, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 4'h1, 4'h1);
      total++; if ({F_stall, D_stall, E_bubble} !== 3'b000) begin bad++; $display("[TB] FAIL lu_none: got %03b want 000", {F_stall, D_stall, E_bubble}); end
      // load-use and ret in D together: stall wins over the D bubble
      applyStimulus(4'h9, 4'h5, 4'h1, 4'h3, 4'hF, 4'h3, 1'b1, 4'h1, 4'h1);
      total++; if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b1101) begin bad++; $display("[TB] FAIL lu_rt_prio: got %04b want 1101", {F_stall, D_stall, D_bubble, E_bubble}); end
   endtask

   task automatic test_ret();
      do_reset();
      applyStimulus(4'h9, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 4'h1, 4'h1);
      total++; if ({F_stall, D_bubble, D_stall} !== 3'b110) begin bad++; $display("[TB] FAIL ret_d: got %03b want 110", {F_stall, D_bubble, D_stall}); end
      tick();
      applyStimulus(4'h1, 4'h9, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 4'h1, 4'h1);
      total++; if ({F_stall, D_bubble} !== 2'b11) begin bad++; $display("[TB] FAIL ret_e: got %02b want 11", {F_stall, D_bubble}); end
      tick();
      applyStimulus(4'h1, 4'h1, 4'h9, 4'hF, 4'hF, 4'hF, 1'b1, 4'h1, 4'h1);
      total++; if ({F_stall, D_bubble} !== 2'b11) begin bad++; $display("[TB] FAIL ret_m: got %02b want 11", {F_stall, D_bubble}); end
      tick();
      idle();
      total++; if ({F_stall, D_bubble} !== 2'b00) begin bad++; $display("[TB] FAIL ret_done: got %02b want 00", {F_stall, D_bubble}); end
      total++; if (bubble_cnt !== 32'd3) begin bad++; $display("[TB] FAIL ret_bubble_cnt: got %0d want 3", bubble_cnt); end
      total++; if (stall_cnt !== 32'd3) begin bad++; $display("[TB] FAIL ret_stall_cnt: got %0d want 3", stall_cnt); end
      tick();
      total++; if ({cyc_cnt, bubble_cnt} !== {32'd4, 32'd3}) begin bad++; $display("[TB] FAIL ret_after: got cyc=%0d bub=%0d want cyc=4 bub=3", cyc_cnt, bubble_cnt); end
   endtask

   task automatic test_mispredict();
      do_reset();
      applyStimulus(4'h9, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 4'h1, 4'h1);
      total++; if ({D_bubble, E_bubble, F_stall, D_stall} !== 4'b1110) begin bad++; $display("[TB] FAIL mp_ret: got %04b want 1110", {D_bubble, E_bubble, F_stall, D_stall}); end
      applyStimulus(4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 4'h1, 4'h1);
      total++; if ({D_bubble, E_bubble} !== 2'b00) begin bad++; $display("[TB] FAIL mp_taken: got %02b want 00", {D_bubble, E_bubble}); end
      applyStimulus(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 4'h1, 4'h1);
      total++; if (set_cc !== 1'b1) begin bad++; $display("[TB] FAIL opq_setcc: got %0b want 1", set_cc); end
   endtask

   task automatic test_exception();
      do_reset();
      applyStimulus(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 4'h3, 4'h1);
      total++; if ({M_bubble, set_cc, W_stall} !== 3'b100) begin bad++; $display("[TB] FAIL exc_m_ctrl: got %03b want 100", {M_bubble, set_cc, W_stall}); end
      tick();
      total++; if (cpu_state !== 2'b01) begin bad++; $display("[TB] FAIL exc_drain: got %0d want 1", cpu_state); end
      m_stat = 4'h1; #1;
      tick();
      total++; if (cpu_state !== 2'b00) begin bad++; $display("[TB] FAIL exc_squash: got %0d want 0", cpu_state); end
      m_stat = 4'h3; #1;
      tick();
      m_stat = 4'h1; W_stat = 4'h3; #1;
      total++; if ({W_stall, M_bubble, set_cc} !== 3'b110) begin bad++; $display("[TB] FAIL exc_w_ctrl: got %03b want 110", {W_stall, M_bubble, set_cc}); end
      tick();
      total++; if (cpu_state !== 2'b10) begin bad++; $display("[TB] FAIL exc_halt: got %0d want 2", cpu_state); end
      idle();
      E_icode = 4'h6; #1;
      for (int i = 0; i < 3; i++) tick();
      total++; if (cpu_state !== 2'b10) begin bad++; $display("[TB] FAIL halt_sticky: got %0d want 2", cpu_state); end
      total++; if ({F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc} !== 7'b1111110) begin bad++; $display("[TB] FAIL halt_ctrl: got %07b want 1111110", {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc}); end
      total++; if ({cyc_cnt, stall_cnt, bubble_cnt} !== {32'd4, 32'd0, 32'd3}) begin bad++; $display("[TB] FAIL halt_cnts: got %0d/%0d/%0d want 4/0/3", cyc_cnt, stall_cnt, bubble_cnt); end
   endtask

   task automatic test_reset_halted();
      // entered from HALTED left by test_exception
      reset = 1'b1; #1;
      total++; if ({F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble} !== 6'b000111) begin bad++; $display("[TB] FAIL rsth_ctrl: got %06b want 000111", {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble}); end
      tick();
      total++; if (cpu_state !== 2'b00) begin bad++; $display("[TB] FAIL rsth_state: got %0d want 0", cpu_state); end
      total++; if ({cyc_cnt, stall_cnt, bubble_cnt} !== 96'd0) begin bad++; $display("[TB] FAIL rsth_cnts: got %0d/%0d/%0d want 0/0/0", cyc_cnt, stall_cnt, bubble_cnt); end
      reset = 1'b0; #1;
      total++; if ({F_stall, D_bubble, E_bubble, M_bubble, set_cc} !== 5'b00001) begin bad++; $display("[TB] FAIL rsth_normal: got %05b want 00001", {F_stall, D_bubble, E_bubble, M_bubble, set_cc}); end
      tick();
      total++; if (cyc_cnt !== 32'd1) begin bad++; $display("[TB] FAIL rsth_resume: got %0d want 1", cyc_cnt); end
   endtask

   task automatic test_saturation();
      do_reset();
      applyStimulus(4'h1, 4'h5, 4'h1, 4'h3, 4'hF, 4'h3, 1'b1, 4'h1, 4'h1);
      for (int i = 0; i < 15; i++) tick();
      total++; if (s_cyc_cnt !== 4'hF) begin bad++; $display("[TB] FAIL sat_reach: got %0h want f", s_cyc_cnt); end
      for (int i = 0; i < 5; i++) tick();
      total++; if (s_cyc_cnt !== 4'hF) begin bad++; $display("[TB] FAIL sat_cyc: got %0h want f", s_cyc_cnt); end
      total++; if ({s_stall_cnt, s_bubble_cnt} !== 8'hFF) begin bad++; $display("[TB] FAIL sat_stall_bub: got %0h/%0h want f/f", s_stall_cnt, s_bubble_cnt); end
      total++; if (cyc_cnt !== 32'd20) begin bad++; $display("[TB] FAIL wide_cyc: got %0d want 20", cyc_cnt); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      idle();
      test_reset();
      test_load_use();
      test_ret();
      test_mispredict();
      test_exception();
      test_reset_halted();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
